// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin pick of one ready result source per cycle,
// broadcast on a registered CDB with a saturating broadcast counter.
module cdb_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned TAG_W  = 8,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ*WORD_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    flush,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [WORD_W-1:0]       cdb_data,
  output logic [CNT_W-1:0]        bcast_cnt
);

  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PtrW-1:0]   rr_q, rr_d;
  logic [PtrW-1:0]   win;
  logic              found;
  logic              valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Grant search starts at the pointer and wraps; reset and flush suppress any grant.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    req_ready = '0;
    win       = '0;
    found     = 1'b0;
    if (!rst && !flush) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        idx = (int'(rr_q) + k) % N_REQ;
        if (!found && req_valid[idx]) begin
          found          = 1'b1;
          req_ready[idx] = 1'b1;
          win            = PtrW'(idx);
        end
      end
    end
  end

  always_comb begin
    valid_d = found;
    tag_d   = tag_q;
    data_d  = data_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    if (found) begin
      tag_d  = req_tag[int'(win)*TAG_W +: TAG_W];
      data_d = req_data[int'(win)*WORD_W +: WORD_W];
      rr_d   = (win == PtrW'(N_REQ - 1)) ? '0 : win + 1'b1;
      if (!(&cnt_q)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cdb_valid = valid_q;
  assign cdb_tag   = tag_q;
  assign cdb_data  = data_q;
  assign bcast_cnt = cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter; a second instance with a 4-bit counter
// shares the stimulus to exercise counter saturation.
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [3:0]   req_valid;
  logic [31:0]  req_tag;
  logic [127:0] req_data;
  logic [3:0]   req_ready, sat_ready;
  logic         cdb_valid, sat_valid;
  logic [7:0]   cdb_tag, sat_tag;
  logic [31:0]  cdb_data, sat_data;
  logic [15:0]  bcast_cnt;
  logic [3:0]   sat_cnt;

  logic [7:0]   tags [4];
  logic [31:0]  words[4];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_tag[i*8 +: 8]    = tags[i];
      req_data[i*32 +: 32] = words[i];
    end
  end

  cdb_arbiter u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .flush     (flush),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .bcast_cnt (bcast_cnt)
  );

  cdb_arbiter #(.CNT_W(4)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (sat_ready),
    .flush     (flush),
    .cdb_valid (sat_valid),
    .cdb_tag   (sat_tag),
    .cdb_data  (sat_data),
    .bcast_cnt (sat_cnt)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Leaves time 1 unit past the rising edge so registered outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      tags[i]  = 8'h10 + 8'(i);
      words[i] = 32'hD000_0000 + 32'(i);
    end
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = 4'b0000;
    #3;
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_cdb_tag", 64'(cdb_tag), 64'd0);
    chk("rst_cnt", 64'(bcast_cnt), 64'd0);

    // 1: all valid while in reset, then release
    req_valid = 4'b1111;
    #1;
    chk("rst_ready", 64'(req_ready), 64'b0000);
    tick();
    chk("rst_hold_valid", 64'(cdb_valid), 64'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("post_rst_grant0", 64'(req_ready), 64'b0001);
    tick();
    chk("post_rst_tag", 64'(cdb_tag), 64'h10);
    chk("post_rst_cnt", 64'(bcast_cnt), 64'd1);
    req_valid = 4'b0000;
    #1;
    chk("idle_ready", 64'(req_ready), 64'd0);
    tick();
    chk("idle_valid", 64'(cdb_valid), 64'd0);
    chk("idle_tag_hold", 64'(cdb_tag), 64'h10);
    chk("idle_cnt_hold", 64'(bcast_cnt), 64'd1);

    // 2: single requester 2 from a fresh reset
    pulse_reset();
    tags[2]   = 8'hA3;
    words[2]  = 32'h1234_5678;
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 64'(req_ready), 64'b0100);
    tick();
    chk("single_valid", 64'(cdb_valid), 64'd1);
    chk("single_tag", 64'(cdb_tag), 64'hA3);
    chk("single_data", 64'(cdb_data), 64'h1234_5678);
    chk("single_cnt", 64'(bcast_cnt), 64'd1);
    req_valid = 4'b1111;
    #1;
    chk("single_ptr3", 64'(req_ready), 64'b1000);

    // 3: all valid for 8 cycles from pointer 0
    pulse_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      tick();
      chk("rr_valid", 64'(cdb_valid), 64'd1);
      chk("rr_tag", 64'(cdb_tag), 64'(tags[k % 4]));
      chk("rr_data", 64'(cdb_data), 64'(words[k % 4]));
    end
    chk("rr_cnt", 64'(bcast_cnt), 64'd8);
    chk("rr_sat_cnt", 64'(sat_cnt), 64'd8);

    // 4: flush wins over valid; registered broadcast survives flush
    flush     = 1'b1;
    req_valid = 4'b0010;
    #1;
    chk("flush_ready", 64'(req_ready), 64'd0);
    chk("flush_keeps_bcast", 64'(cdb_valid), 64'd1);
    tick();
    chk("flush_valid", 64'(cdb_valid), 64'd0);
    chk("flush_tag_hold", 64'(cdb_tag), 64'(tags[3]));
    chk("flush_cnt", 64'(bcast_cnt), 64'd8);
    flush = 1'b0;
    #1;
    chk("unflush_grant1", 64'(req_ready), 64'b0010);
    tick();
    chk("unflush_tag", 64'(cdb_tag), 64'(tags[1]));
    chk("unflush_cnt", 64'(bcast_cnt), 64'd9);
    flush     = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("flush_all_ready", 64'(req_ready), 64'd0);
    tick();
    flush     = 1'b0;
    req_valid = 4'b0011;
    #1;
    chk("ptr_unchanged", 64'(req_ready), 64'b0001);
    chk("ptr_unchanged_sat", 64'(sat_ready), 64'b0001);

    // 5: 20 back-to-back grants saturate the 4-bit counter
    req_valid = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 5) chk("sat_reach", 64'(sat_cnt), 64'd15);
    end
    chk("sat_stop", 64'(sat_cnt), 64'd15);
    chk("sat_valid", 64'(sat_valid), 64'd1);
    chk("wide_cnt", 64'(bcast_cnt), 64'd29);

    // 6: asynchronous reset mid-stream, between edges
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", 64'(cdb_valid), 64'd0);
    chk("async_tag", 64'(cdb_tag), 64'd0);
    chk("async_data", 64'(cdb_data), 64'd0);
    chk("async_cnt", 64'(bcast_cnt), 64'd0);
    chk("async_sat_cnt", 64'(sat_cnt), 64'd0);
    chk("async_ready", 64'(req_ready), 64'd0);
    #1;
    rst = 1'b0;
    #1;
    chk("restart_ready", 64'(req_ready), 64'b0001);
    tick();
    chk("restart_tag", 64'(cdb_tag), 64'(tags[0]));
    chk("restart_data", 64'(sat_data), 64'(words[0]));
    chk("restart_cnt", 64'(bcast_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
